// File: rtl/tgc_pipe.sv
// Two-stage pipelined triangle-condition checker with valid/ready flow control and saturating counters.
// Optional macro TGC_RIGHT_EN adds sorted-side squares and a right-angle output `right`.
module tgc_pipe #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          q,
  output logic [1:0]    kind,
  output logic [CW-1:0] tri_cnt,
  output logic [CW-1:0] tot_cnt
`ifdef TGC_RIGHT_EN
  ,
  output logic          right
`endif
);

  logic          s1_valid_q, s1_valid_d;
  logic [W:0]    sum_ab_q, sum_ab_d, sum_ac_q, sum_ac_d, sum_bc_q, sum_bc_d;
  logic [W-1:0]  sa_q, sa_d, sb_q, sb_d, sc_q, sc_d;
  logic          eq_ab_q, eq_ab_d, eq_bc_q, eq_bc_d, eq_ac_q, eq_ac_d;
  logic          zero_q, zero_d;

  logic          out_valid_q, out_valid_d;
  logic          q_q, q_d;
  logic [1:0]    kind_q, kind_d;
  logic [CW-1:0] tri_q, tri_d, tot_q, tot_d;

  logic          s2_adv;
  logic          q_calc;
  logic [1:0]    kind_calc;

`ifdef TGC_RIGHT_EN
  logic [W-1:0]  lo, hi, pmin, pmax, rest;
  logic [2*W:0]  sq_lo_q, sq_lo_d, sq_mid_q, sq_mid_d, sq_hi_q, sq_hi_d;
  logic          right_q, right_d, right_calc;
`endif

  // Stage 2 can take new data when empty or when its result leaves this cycle.
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    sum_ab_d   = sum_ab_q;
    sum_ac_d   = sum_ac_q;
    sum_bc_d   = sum_bc_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    sc_d       = sc_q;
    eq_ab_d    = eq_ab_q;
    eq_bc_d    = eq_bc_q;
    eq_ac_d    = eq_ac_q;
    zero_d     = zero_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        sum_ab_d = {1'b0, a} + {1'b0, b};
        sum_ac_d = {1'b0, a} + {1'b0, c};
        sum_bc_d = {1'b0, b} + {1'b0, c};
        sa_d     = a;
        sb_d     = b;
        sc_d     = c;
        eq_ab_d  = (a == b);
        eq_bc_d  = (b == c);
        eq_ac_d  = (a == c);
        zero_d   = (a == '0) || (b == '0) || (c == '0);
      end
    end
  end

`ifdef TGC_RIGHT_EN
  // Three-input sort: order (a,b), then the larger of those competes with c for max.
  always_comb begin
    pmin     = (a > b) ? b : a;
    pmax     = (a > b) ? a : b;
    hi       = (pmax > c) ? pmax : c;
    rest     = (pmax > c) ? c : pmax;
    lo       = (pmin > rest) ? rest : pmin;
    sq_lo_d  = sq_lo_q;
    sq_mid_d = sq_mid_q;
    sq_hi_d  = sq_hi_q;
    if (in_ready && in_valid) begin
      sq_lo_d  = {{(W+1){1'b0}}, lo} * {{(W+1){1'b0}}, lo};
      sq_mid_d = {{(W+1){1'b0}}, ((pmin > rest) ? pmin : rest)} *
                 {{(W+1){1'b0}}, ((pmin > rest) ? pmin : rest)};
      sq_hi_d  = {{(W+1){1'b0}}, hi} * {{(W+1){1'b0}}, hi};
    end
  end
`endif

  always_comb begin
    q_calc = (sum_ab_q > {1'b0, sc_q}) && (sum_ac_q > {1'b0, sb_q}) &&
             (sum_bc_q > {1'b0, sa_q}) && !zero_q;
    if (!q_calc)
      kind_calc = 2'd0;
    else if (eq_ab_q && eq_bc_q)
      kind_calc = 2'd3;
    else if (eq_ab_q || eq_bc_q || eq_ac_q)
      kind_calc = 2'd2;
    else
      kind_calc = 2'd1;
`ifdef TGC_RIGHT_EN
    right_calc = q_calc && ((sq_lo_q + sq_mid_q) == sq_hi_q);
`endif
  end

  // Result registers only load new data, so q/kind stay frozen while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    q_d         = q_q;
    kind_d      = kind_q;
`ifdef TGC_RIGHT_EN
    right_d     = right_q;
`endif
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        q_d    = q_calc;
        kind_d = kind_calc;
`ifdef TGC_RIGHT_EN
        right_d = right_calc;
`endif
      end
    end
  end

  always_comb begin
    tri_d = tri_q;
    tot_d = tot_q;
    if (clr) begin
      tri_d = '0;
      tot_d = '0;
    end else if (out_valid_q && out_ready) begin
      if (tot_q != '1)
        tot_d = tot_q + CW'(1);
      if (q_q && (tri_q != '1))
        tri_d = tri_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      sum_ab_q    <= '0;
      sum_ac_q    <= '0;
      sum_bc_q    <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      sc_q        <= '0;
      eq_ab_q     <= 1'b0;
      eq_bc_q     <= 1'b0;
      eq_ac_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= 1'b0;
      kind_q      <= 2'd0;
      tri_q       <= '0;
      tot_q       <= '0;
`ifdef TGC_RIGHT_EN
      sq_lo_q     <= '0;
      sq_mid_q    <= '0;
      sq_hi_q     <= '0;
      right_q     <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      sum_ab_q    <= sum_ab_d;
      sum_ac_q    <= sum_ac_d;
      sum_bc_q    <= sum_bc_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      sc_q        <= sc_d;
      eq_ab_q     <= eq_ab_d;
      eq_bc_q     <= eq_bc_d;
      eq_ac_q     <= eq_ac_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      kind_q      <= kind_d;
      tri_q       <= tri_d;
      tot_q       <= tot_d;
`ifdef TGC_RIGHT_EN
      sq_lo_q     <= sq_lo_d;
      sq_mid_q    <= sq_mid_d;
      sq_hi_q     <= sq_hi_d;
      right_q     <= right_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign kind      = kind_q;
  assign tri_cnt   = tri_q;
  assign tot_cnt   = tot_q;
`ifdef TGC_RIGHT_EN
  assign right     = right_q;
`endif

endmodule

// File: tb/tb_tgc_pipe.sv
// Randomized and directed bench for tgc_pipe against a queue-based reference model.
// A second instance with CW=2 shares the stimulus to exercise counter saturation.
module tb_tgc_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = '0, b = '0, c = '0;
  logic        in_ready, out_valid, q;
  logic [1:0]  kind;
  logic [15:0] tri_cnt, tot_cnt;
  logic        in_ready2, out_valid2, q2;
  logic [1:0]  kind2, tri_cnt2, tot_cnt2;
`ifdef TGC_RIGHT_EN
  logic        right, right2;
`endif

  tgc_pipe #(.W(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready), .q(q),
    .kind(kind), .tri_cnt(tri_cnt), .tot_cnt(tot_cnt)
`ifdef TGC_RIGHT_EN
    , .right(right)
`endif
  );

  tgc_pipe #(.W(8), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .c(c), .out_valid(out_valid2), .out_ready(out_ready), .q(q2),
    .kind(kind2), .tri_cnt(tri_cnt2), .tot_cnt(tot_cnt2)
`ifdef TGC_RIGHT_EN
    , .right(right2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int kind;
    int rt;
    int tin;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_pop = -100;
  int   m_tri = 0;
  int   m_tot = 0;
  bit   acc = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic exp_t model(input int x, input int y, input int z, input int t);
    exp_t e;
    int   s[3];
    int   tmp;
    e.tin = t;
    e.q = (x > 0 && y > 0 && z > 0 && x + y > z && x + z > y && y + z > x) ? 1 : 0;
    if (e.q == 0) e.kind = 0;
    else if (x == y && y == z) e.kind = 3;
    else if (x == y || y == z || x == z) e.kind = 2;
    else e.kind = 1;
    s[0] = x; s[1] = y; s[2] = z;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (s[j] > s[j+1]) begin
          tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp;
        end
    e.rt = (e.q == 1 && s[0]*s[0] + s[1]*s[1] == s[2]*s[2]) ? 1 : 0;
    return e;
  endfunction

  // One clock: check outputs at the falling edge, advance the model, then cross the rising edge.
  task automatic step();
    int  n;
    int  ready_at;
    bit  exp_ov;
    bit  out_x;
    @(negedge clk);
    n = sb.size();
    check("in_ready", int'(in_ready), (n < 2 || out_ready) ? 1 : 0);
    exp_ov = 1'b0;
    if (n > 0) begin
      ready_at = (sb[0].tin + 2 > last_pop + 1) ? sb[0].tin + 2 : last_pop + 1;
      exp_ov = (cyc >= ready_at);
    end
    check("out_valid", int'(out_valid), int'(exp_ov));
    check("tot_cnt", int'(tot_cnt), sat(m_tot, 65535));
    check("tri_cnt", int'(tri_cnt), sat(m_tri, 65535));
    check("tot_cnt_cw2", int'(tot_cnt2), sat(m_tot, 3));
    check("tri_cnt_cw2", int'(tri_cnt2), sat(m_tri, 3));
    if (out_valid) begin
      if (n == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("q", int'(q), sb[0].q);
        check("kind", int'(kind), sb[0].kind);
`ifdef TGC_RIGHT_EN
        check("right", int'(right), sb[0].rt);
`endif
      end
    end
    out_x = out_valid && out_ready && (n > 0);
    if (clr) begin
      m_tri = 0;
      m_tot = 0;
    end else if (out_x) begin
      m_tot++;
      m_tri += sb[0].q;
    end
    if (out_x) begin
      void'(sb.pop_front());
      last_pop = cyc;
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back(model(int'(a), int'(b), int'(c), cyc));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input int x, input int y, input int z);
    a = 8'(x); b = 8'(y); c = 8'(z);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  int k, rot, mode;
  int t3[3];

  initial begin
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_q", int'(q), 0);
    check("rst_kind", int'(kind), 0);
    check("rst_tri", int'(tri_cnt), 0);
    check("rst_tot", int'(tot_cnt), 0);
`ifdef TGC_RIGHT_EN
    check("rst_right", int'(right), 0);
`endif
    rst_n = 1'b1;

    // Back-to-back stream at full throughput.
    send(3, 4, 10); send(3, 4, 5); send(7, 7, 7);
    idle(4);
    check("t1_tri", int'(tri_cnt), 2);
    check("t1_tot", int'(tot_cnt), 3);

    // Wide sums, degenerate and zero sides.
    send(149, 42, 149); send(2, 3, 5); send(0, 0, 0); send(255, 255, 255);
    idle(4);

    // Backpressure: two held, third refused until release.
    out_ready = 1'b0;
    a = 8'd3; b = 8'd4; c = 8'd5; in_valid = 1'b1; step();
    check("bp_acc1", int'(acc), 1);
    a = 8'd5; b = 8'd5; c = 8'd8; step();
    check("bp_acc2", int'(acc), 1);
    a = 8'd1; b = 8'd1; c = 8'd9;
    repeat (3) step();
    check("bp_held", int'(acc), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc) break;
    end
    check("bp_acc3", int'(acc), 1);
    idle(4);

    // Saturation of the CW=2 copy, then clear coinciding with a transfer.
    clr = 1'b1; step(); clr = 1'b0;
    repeat (5) send(3, 4, 5);
    idle(3);
    check("sat_tri_cw2", int'(tri_cnt2), 3);
    check("sat_tot_cw2", int'(tot_cnt2), 3);
    send(6, 6, 6);
    step();
    check("clr_pre_ov", int'(out_valid), 1);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_xfer_tot", int'(tot_cnt), 0);
    check("clr_xfer_tri", int'(tri_cnt), 0);
    idle(2);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr       = ($urandom % 50) == 0;
      mode      = $urandom % 4;
      if (mode == 0) begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      end else if (mode == 3) begin
        k = $urandom_range(1, 20);
        t3[0] = 3 * k; t3[1] = 4 * k; t3[2] = 5 * k;
        rot = $urandom % 3;
        a = 8'(t3[rot]); b = 8'(t3[(rot + 1) % 3]); c = 8'(t3[(rot + 2) % 3]);
      end else begin
        a = 8'($urandom_range(0, 12)); b = 8'($urandom_range(0, 12)); c = 8'($urandom_range(0, 12));
      end
      step();
    end
    clr = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset with two triples in flight.
    send(3, 4, 5); send(6, 6, 6);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_tot", int'(tot_cnt), 0);
    check("arst_tri", int'(tri_cnt), 0);
    check("arst_tot_cw2", int'(tot_cnt2), 0);
    sb.delete();
    m_tri = 0;
    m_tot = 0;
    last_pop = -100;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(6, 8, 10);
    idle(4);
    check("post_rst_tri", int'(tri_cnt), 1);
    check("post_rst_tot", int'(tot_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
